// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants, load-state enum and digit helpers for the
//               multiplexed BCD display scanner.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;
  localparam int WORD_W  = DIGITS * BCD_W;
  localparam int IDX_W   = $clog2(DIGITS);

  // EMPTY: shadow is free to take a load. PENDING: shadow waits for a frame end.
  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } load_state_t;

  // Nibble i of a packed digit word.
  function automatic logic [BCD_W-1:0] digit_at(input logic [WORD_W-1:0] word,
                                                input logic [IDX_W-1:0]  i);
    return word[i*BCD_W +: BCD_W];
  endfunction

  // True when any nibble lies outside the BCD range.
  function automatic logic has_bad_digit(input logic [WORD_W-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (word[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running prescaler. Counts 0..PRESCALE-1 and raises tick
//               for the single cycle in which the count sits at PRESCALE-1.
// Ports       : clk  - system clock (rising edge)
//               rst  - asynchronous active-high reset, clears the count
//               tick - one-cycle strobe at the terminal count
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // A prescale of 1 still needs a one-bit counter; it simply never leaves 0,
  // so tick stays high every cycle.
  localparam int           CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == TERM) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == TERM);

endmodule : tick_gen
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scanner
// Description : Time-multiplexes four BCD digits onto one seven-segment
//               decoder. New values are double-buffered through a shadow
//               register and only committed at a frame boundary so a frame is
//               never torn. Optional leading-zero blanking.
// Ports       : clk        - system clock (rising edge)
//               rst        - asynchronous active-high reset
//               load_valid - load_data valid this cycle
//               load_ready - block can accept a load this cycle
//               load_data  - four BCD digits, [3:0] = digit0
//               blank_lz   - enable leading-zero blanking
//               num        - code of the current digit (to decoder)
//               dig_en     - one-hot / all-zero digit enable
//               err        - sticky: an accepted load held a nibble > 9
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner
  import disp_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int DIGITS   = disp_pkg::DIGITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [DIGITS*BCD_W-1:0]   load_data,
  input  logic                      blank_lz,
  output logic [BCD_W-1:0]          num,
  output logic [DIGITS-1:0]         dig_en,
  output logic                      err
);

  logic                     tick;
  logic [IDX_W-1:0]         idx;
  logic [DIGITS*BCD_W-1:0]  active;
  logic [DIGITS*BCD_W-1:0]  shadow;
  load_state_t              state;
  load_state_t              state_nxt;
  logic                     capture;
  logic                     commit;
  logic                     frame_end;
  logic [DIGITS-1:0]        dig_sel;
  logic [DIGITS-1:0]        blank_mask;
  logic                     nz_above;
  logic [BCD_W-1:0]         cur_digit;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_end = tick && (idx == IDX_W'(DIGITS - 1));

  // ---------------------------------------------------------------- load FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // load_valid is only looked at in EMPTY, so data offered while PENDING is
  // dropped and need not be held by the producer.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      EMPTY: begin
        load_ready = 1'b1;
        if (load_valid) begin
          capture   = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          commit    = 1'b1;
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  // ---------------------------------------------------------- digit select
  assign cur_digit = digit_at(active, idx);
  assign dig_sel   = DIGITS'(1) << idx;

  // Walk from the top digit down; a digit is blanked while nothing at or
  // above it is nonzero. Digit0 is excluded so an all-zero word shows "0".
  // Codes above 9 are nonzero and therefore stop the blanking.
  always_comb begin
    nz_above   = 1'b0;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz_above      = nz_above | (active[i*BCD_W +: BCD_W] != '0);
      blank_mask[i] = blank_lz & ~nz_above;
    end
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      active <= '0;
      shadow <= '0;
      num    <= '0;
      dig_en <= DIGITS'(1);
      err    <= 1'b0;
    end else begin
      if (tick) begin
        idx <= idx + IDX_W'(1);
      end
      if (capture) begin
        shadow <= load_data;
      end
      // active only ever moves at a frame boundary, so a frame is untorn.
      if (commit) begin
        active <= shadow;
      end
      if (capture && has_bad_digit(load_data)) begin
        err <= 1'b1;
      end
      num    <= cur_digit;
      dig_en <= dig_sel & ~blank_mask;
    end
  end

endmodule : bcd_display_scanner
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_scanner
// Description : Self-checking bench. Two scanners (PRESCALE=4 and PRESCALE=1)
//               share one stimulus stream; each is compared every cycle with a
//               behavioural model that derives timing from the cycle count
//               since reset release and digit data from shifts of the word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        blank_lz;

  logic        ready_a, err_a, ready_b, err_b;
  logic [3:0]  num_a, den_a, num_b, den_b;

  int errors = 0;
  int checks = 0;

  // model state, index 0 = PRESCALE 4, index 1 = PRESCALE 1
  int          pre_tab [2] = '{4, 1};
  int          kcyc    [2];
  logic [15:0] m_active[2];
  logic [15:0] m_shadow[2];
  bit          m_pend  [2];
  bit          m_err   [2];
  logic [3:0]  e_num   [2];
  logic [3:0]  e_den   [2];

  bcd_display_scanner #(.PRESCALE(4), .DIGITS(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (ready_a),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .num        (num_a),
    .dig_en     (den_a),
    .err        (err_a)
  );

  bcd_display_scanner #(.PRESCALE(1), .DIGITS(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (ready_b),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .num        (num_b),
    .dig_en     (den_b),
    .err        (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_num_p4"},   32'(num_a),   32'(e_num[0]));
    check({tag, "_den_p4"},   32'(den_a),   32'(e_den[0]));
    check({tag, "_rdy_p4"},   32'(ready_a), 32'(!m_pend[0]));
    check({tag, "_err_p4"},   32'(err_a),   32'(m_err[0]));
    check({tag, "_num_p1"},   32'(num_b),   32'(e_num[1]));
    check({tag, "_den_p1"},   32'(den_b),   32'(e_den[1]));
    check({tag, "_rdy_p1"},   32'(ready_b), 32'(!m_pend[1]));
    check({tag, "_err_p1"},   32'(err_b),   32'(m_err[1]));
  endtask

  // One rising edge of the reference: k edges after reset release the
  // prescaler sits at k % P and the shown digit is (k / P) % 4.
  task automatic model_edge(input int u);
    int p, id;
    bit tk;
    p  = pre_tab[u];
    id = (kcyc[u] / p) % 4;
    tk = ((kcyc[u] % p) == p - 1);
    e_num[u] = 4'((m_active[u] >> (4 * id)) & 16'hF);
    if (id == 0 || !blank_lz || (m_active[u] >> (4 * id)) != 16'h0)
      e_den[u] = 4'(1 << id);
    else
      e_den[u] = 4'h0;
    if (!m_pend[u]) begin
      if (load_valid) begin
        for (int n = 0; n < 4; n++)
          if (((load_data >> (4 * n)) & 16'hF) > 9) m_err[u] = 1'b1;
        m_shadow[u] = load_data;
        m_pend[u]   = 1'b1;
      end
    end else if (tk && id == 3) begin
      m_active[u] = m_shadow[u];
      m_pend[u]   = 1'b0;
    end
    kcyc[u]++;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      kcyc[u]     = 0;
      m_active[u] = 16'h0;
      m_shadow[u] = 16'h0;
      m_pend[u]   = 1'b0;
      m_err[u]    = 1'b0;
      e_num[u]    = 4'h0;
      e_den[u]    = 4'b0001;
    end
    compare_all("rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all("rst_hold");
    end
    rst = 1'b0;
  endtask

  task automatic load_once(input logic [15:0] d, input string tag);
    load_valid = 1'b1;
    load_data  = d;
    step(tag);
    load_valid = 1'b0;
    load_data  = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    w = '0;
    for (int n = 0; n < 4; n++) w = w | (16'($urandom_range(0, 9)) << (4 * n));
    return w;
  endfunction

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    blank_lz   = 1'b0;
    #2;
    do_reset();

    // idle rotation after reset
    run(20, "idle");

    // single load, then watch it commit at the frame boundary
    load_once(16'h1234, "ld1234");
    run(40, "show1234");

    // continuous valid with changing data
    load_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      load_data = rand_bcd();
      step("hold");
    end
    load_valid = 1'b0;
    run(20, "hold_drain");

    // leading-zero blanking on and off
    blank_lz = 1'b1;
    load_once(16'h0070, "ld0070");
    run(40, "blank_on");
    blank_lz = 1'b0;
    run(20, "blank_off");
    blank_lz = 1'b1;
    load_once(16'h0000, "ld0000");
    run(40, "blank_zero");
    blank_lz = 1'b0;

    // out-of-range digit sets the sticky flag
    load_once(16'h00A5, "ld00A5");
    run(30, "bad");
    load_once(16'h0001, "ld0001");
    run(30, "sticky");

    // reset while a 9999 load is still pending
    run(2, "pre9");
    load_once(16'h9999, "ld9999");
    run(1, "pend9");
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step("post9");
      check("no9_p4", 32'(num_a == 4'd9), 32'd0);
      check("no9_p1", 32'(num_b == 4'd9), 32'd0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 99) < 30);
      load_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : rand_bcd();
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bcd_display_scanner
`default_nettype wire
